// File: rtl/state_feeder_pkg.sv
// Shared constants and FSM encoding for the AES state feeder.
package state_feeder_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int STATE_W  = 128;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

endpackage

// File: rtl/state_feeder_byte_sel.sv
// state_byte_sel: picks byte (row, col) of a column-major 128-bit AES state.
module state_byte_sel
    import state_feeder_pkg::*;
(
    input  logic [STATE_W-1:0] block,
    input  logic [1:0]         row,
    input  logic [1:0]         col,
    output logic [7:0]         sel_byte
);

    logic [3:0] idx;
    logic [6:0] lsb;

    // Byte i sits at [127-8i -: 8]; i = 4*col + row.
    assign idx      = {col, row};
    assign lsb      = 7'd120 - {idx, 3'b000};
    assign sel_byte = block[lsb +: 8];

endmodule

// File: rtl/state_feeder.sv
// Feeds an AES state column-by-column into a PE array and returns the psums.
// Optional block counter output enabled by STATE_FEEDER_STATS_EN.
module state_feeder
    import state_feeder_pkg::*;
#(
    parameter int NUM_ROWS = state_feeder_pkg::NUM_ROWS,
    parameter int NUM_COLS = state_feeder_pkg::NUM_COLS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_block,
    output logic               pe_en,
    output logic               shift_in_en,
    output logic [31:0]        west_data,
    input  logic               array_done,
    input  logic [STATE_W-1:0] psum_flat,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_block,
`ifdef STATE_FEEDER_STATS_EN
    output logic [15:0]        blk_count,
`endif
    output logic               busy
);

    logic [1:0]         state;
    logic [1:0]         k;
    logic [STATE_W-1:0] blk;
    logic [STATE_W-1:0] out_q;
    logic [1:0]         col_sel;
    logic               shifting;

    assign shifting    = (state == S_SHIFT);
    assign in_ready    = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign out_valid   = (state == S_DRAIN);
    assign pe_en       = shifting;
    assign shift_in_en = shifting;
    assign out_block   = out_q;

    // Last column goes in first so column c lands in PE column c.
    assign col_sel = 2'(NUM_COLS - 1) - k;

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        logic [7:0] b;

        state_byte_sel u_sel (
            .block    (blk),
            .row      (2'(r)),
            .col      (col_sel),
            .sel_byte (b)
        );

        assign west_data[8*r +: 8] = shifting ? b : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            k     <= 2'd0;
            blk   <= '0;
            out_q <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        blk   <= in_block;
                        k     <= 2'd0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (k == 2'd3) state <= S_WAIT;
                    else           k     <= k + 2'd1;
                end
                S_WAIT: begin
                    if (array_done) begin
                        out_q <= psum_flat;
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef STATE_FEEDER_STATS_EN
    logic [15:0] blk_count_q;

    always_ff @(posedge clk) begin
        if (rst)
            blk_count_q <= 16'd0;
        else if (out_valid && out_ready)
            blk_count_q <= blk_count_q + 16'd1;
    end

    assign blk_count = blk_count_q;
`endif

endmodule

// File: tb/tb_state_feeder.sv
// Directed self-checking bench for state_feeder.
module tb_state_feeder;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic         pe_en;
    logic         shift_in_en;
    logic [31:0]  west_data;
    logic         array_done;
    logic [127:0] psum_flat;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         busy;
`ifdef STATE_FEEDER_STATS_EN
    logic [15:0]  blk_count;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PT2  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PSUM = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] JUNK = 128'hdeadbeefcafef00d0123456789abcdef;

    // Column-major byte order: k=0 sends column 3 (bytes 12..15).
    logic [31:0] exp_pt  [4] = '{32'hffeeddcc, 32'hbbaa9988,
                                 32'h77665544, 32'h33221100};
    logic [31:0] exp_pt2 [4] = '{32'h0f0e0d0c, 32'h0b0a0908,
                                 32'h07060504, 32'h03020100};

    state_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_block    (in_block),
        .pe_en       (pe_en),
        .shift_in_en (shift_in_en),
        .west_data   (west_data),
        .array_done  (array_done),
        .psum_flat   (psum_flat),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_block   (out_block),
`ifdef STATE_FEEDER_STATS_EN
        .blk_count   (blk_count),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_and_shift(input logic [127:0] blk,
                                  input logic [31:0] e0, input logic [31:0] e1,
                                  input logic [31:0] e2, input logic [31:0] e3,
                                  input string nm);
        logic [31:0] exp_w [4];
        exp_w = '{e0, e1, e2, e3};
        in_block = blk;
        in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_in_ready got %b want 1", nm, in_ready);
        end
        tick();
        in_valid = 1'b0;
        in_block = '0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (west_data !== exp_w[k] || shift_in_en !== 1'b1 ||
                pe_en !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_shift%0d got w=%h se=%b pe=%b rdy=%b want w=%h 1 1 0",
                         nm, k, west_data, shift_in_en, pe_en, in_ready, exp_w[k]);
            end
            tick();
        end
        checks++;
        if (shift_in_en !== 1'b0 || pe_en !== 1'b0 || west_data !== 32'h0 ||
            busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_wait got se=%b pe=%b w=%h busy=%b ov=%b want 0 0 0 1 0",
                     nm, shift_in_en, pe_en, west_data, busy, out_valid);
        end
    endtask

    task automatic capture(input logic [127:0] val, input string nm);
        psum_flat  = val;
        array_done = 1'b1;
        tick();
        array_done = 1'b0;
        psum_flat  = JUNK;
        checks++;
        if (out_valid !== 1'b1 || out_block !== val) begin
            errors++;
            $display("FAIL %s_capture got ov=%b blk=%h want 1 %h",
                     nm, out_valid, out_block, val);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || pe_en !== 1'b0 ||
            shift_in_en !== 1'b0 || busy !== 1'b0 || west_data !== 32'h0 ||
            out_block !== 128'h0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b ov=%b pe=%b se=%b busy=%b w=%h ob=%h",
                     in_ready, out_valid, pe_en, shift_in_en, busy, west_data, out_block);
        end
        rst = 1'b0;
        in_block = PT;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (shift_in_en !== 1'b1 || west_data !== 32'hbbaa9988) begin
            errors++;
            $display("FAIL reset_pre_shift got se=%b w=%h want 1 bbaa9988",
                     shift_in_en, west_data);
        end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || west_data !== 32'h0 ||
            busy !== 1'b0 || shift_in_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_shift got rdy=%b ov=%b w=%h busy=%b se=%b want 1 0 0 0 0",
                     in_ready, out_valid, west_data, busy, shift_in_en);
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || shift_in_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort got busy=%b se=%b want 0 0", busy, shift_in_en);
        end
    endtask

    task automatic test_shift_capture();
        load_and_shift(PT, exp_pt[0], exp_pt[1], exp_pt[2], exp_pt[3], "fips");
        tick();
        tick();
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || shift_in_en !== 1'b0) begin
            errors++;
            $display("FAIL wait_hold got busy=%b ov=%b se=%b want 1 0 0",
                     busy, out_valid, shift_in_en);
        end
        capture(PSUM, "fips");
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_block !== PSUM || in_ready !== 1'b0 ||
                busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d got ov=%b ob=%h rdy=%b busy=%b",
                         i, out_valid, out_block, in_ready, busy);
            end
        end
        in_valid = 1'b1;
        in_block = PT2;
        drain();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 ||
            shift_in_en !== 1'b0) begin
            errors++;
            $display("FAIL drain_to_idle got busy=%b rdy=%b ov=%b se=%b want 0 1 0 0",
                     busy, in_ready, out_valid, shift_in_en);
        end
        in_valid = 1'b0;
        in_block = '0;
    endtask

    task automatic test_ignore_done();
        psum_flat  = JUNK;
        array_done = 1'b1;
        tick();
        array_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_in_idle got busy=%b ov=%b want 0 0", busy, out_valid);
        end
        in_block = PT2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        array_done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (shift_in_en !== 1'b1 || west_data !== exp_pt2[k]) begin
                errors++;
                $display("FAIL done_in_shift%0d got se=%b w=%h want 1 %h",
                         k, shift_in_en, west_data, exp_pt2[k]);
            end
            tick();
        end
        array_done = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || shift_in_en !== 1'b0 ||
            out_block !== PSUM) begin
            errors++;
            $display("FAIL done_shift_no_cap got ov=%b busy=%b se=%b ob=%h",
                     out_valid, busy, shift_in_en, out_block);
        end
        capture(PSUM ^ PT2, "second");
        psum_flat  = JUNK;
        array_done = 1'b1;
        tick();
        array_done = 1'b0;
        checks++;
        if (out_block !== (PSUM ^ PT2) || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL done_in_drain got ob=%h ov=%b want %h 1",
                     out_block, out_valid, PSUM ^ PT2);
        end
        drain();
    endtask

`ifdef STATE_FEEDER_STATS_EN
    task automatic run_block();
        in_block = PT;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        capture(PSUM, "stats");
        drain();
    endtask

    task automatic test_stats();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (blk_count !== 16'd0) begin
            errors++;
            $display("FAIL stats_reset got %h want 0000", blk_count);
        end
        repeat (3) run_block();
        checks++;
        if (blk_count !== 16'd3) begin
            errors++;
            $display("FAIL stats_three got %h want 0003", blk_count);
        end
        force dut.blk_count_q = 16'hffff;
        tick();
        release dut.blk_count_q;
        run_block();
        checks++;
        if (blk_count !== 16'd0) begin
            errors++;
            $display("FAIL stats_wrap got %h want 0000", blk_count);
        end
    endtask
`endif

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_block   = '0;
        array_done = 1'b0;
        psum_flat  = '0;
        out_ready  = 1'b0;
        #1;
        test_reset();
        test_shift_capture();
        test_backpressure();
        test_ignore_done();
`ifdef STATE_FEEDER_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
